traffic_light_monitor: RTL
==========================

// Module: traffic_light_monitor
// PURPOSE
//  Receive-side checker for the traffic controller's seven-segment light outputs.
//  - Decodes the 8 hex buses (4 traffic lights, 4 walk lights) back into light states.
//  - Checks the safety and sequencing rules; holds sticky error flags for the exam testbench.
//  - Sits beside the controller, same clock domain, and drives the test_error LED.
// PARAMETERS
//  SETTLE     2        consecutive equal raw decodes required before a state is accepted
//  MIN_AMBER  3        minimum amber duration, counted in tick pulses
//  WALK_PAT   7'h0C    walk-hex pattern meaning WALK; any other pattern means not walking
// PORTS
//  clk_27             in   1  system clock
//  not_reset          in   1  synchronous, active-low reset
//  tick               in   1  timebase enable (1 Hz normal, faster in debug), one cycle wide
//  clear_errors       in   1  synchronous clear of flags, first_error and error_count
//  north_traffic_hex  in   7  northbound light segments, active-low
//  south_hex          in   7  southbound light segments, active-low; [2:1] is the left arrow
//  east_light_hex     in   7  eastbound light segments, active-low
//  west_light_hex     in   7  westbound light segments, active-low
//  north_walk_hex     in   7  northbound walk display segments
//  south_walk_hex     in   7  southbound walk display segments
//  east_walk_hex      in   7  eastbound walk display segments
//  west_walk_hex      in   7  westbound walk display segments
//  light_state        out  8  accepted states {N,S,E,W}, 2 bits each: 00 RED, 01 AMBER, 10 GREEN, 11 INVALID
//  left_arrow_on      out  1  accepted southbound arrow state
//  error_flags        out  6  sticky violations, bit map below
//  test_error         out  1  OR of error_flags
//  first_error        out  3  code of the first violation: bit index + 1; 0 means none
//  error_count        out  8  number of violation cycles, saturates at 255
// BEHAVIOUR
//  Input stage: all hex inputs are registered once.
//  Decode, per light, on the registered hex (segment is lit when 0):
//   - seg0 alone lit  -> RED
//   - seg6 alone lit  -> AMBER
//   - seg3 alone lit  -> GREEN
//   - none or more than one of seg0/3/6 lit -> INVALID
//   - Arrow raw = ~south[2] | ~south[1].
//   - Walk raw = (hex == WALK_PAT). NS walk = N|S walk; EW walk = E|W walk.
//  Settle filter: one per signal.
//   - The accepted value updates only after the raw value has been equal for SETTLE consecutive cycles.
//   - All checks use accepted values only.
//  Latency: offending input at cycle t -> error flag high at t+SETTLE+2.
//  Axis busy: an axis is busy when any of its lights is AMBER, GREEN or INVALID.
//  error_flags bit map:
//   [0] CONFLICT: NS axis and EW axis busy in the same cycle.
//   [1] SEQUENCE: illegal accepted transition: GREEN->RED, RED->AMBER or AMBER->GREEN.
//       Transitions into or out of INVALID are not sequence errors.
//   [2] SHORT_AMBER: AMBER->RED with amber_cnt < MIN_AMBER.
//   [3] WALK_CONFLICT: NS walk while E or W not RED, or EW walk while N or S not RED.
//   [4] ARROW_CONFLICT: arrow on while N, E or W not RED.
//   [5] INVALID: any light accepted as INVALID.
//  Amber counters: one per light, 8-bit, saturating.
//   - Cleared on the cycle AMBER is accepted; entry wins over a coincident tick.
//   - Incremented on each tick while AMBER.
//  Flags: sticky until clear_errors or reset.
//  first_error:
//   - Loaded only on a cycle where any violation is detected while all flags are 0.
//   - Simultaneous violations load the lowest bit index.
//  error_count: +1 per cycle with at least one detected violation, new or repeat.
//  clear_errors: has priority over violations detected in the same cycle.
//  Reset (not_reset=0 at an edge), including mid-operation:
//   - light_state = 8'h00 (all RED), left_arrow_on = 0.
//   - Filter histories and amber counters = 0.
//   - error_flags = 0, test_error = 0, first_error = 0, error_count = 0.
//   - The first transition after reset from RED to GREEN is legal.
// TESTING
//  1. Legal cycle. NS G -> A for 3 ticks -> R, then EW G -> A -> R; arrow only while E/W/N red.
//     -> error_flags stays 6'h00.
//  2. Conflict. N=GREEN with E=GREEN held for 4 cycles.
//     -> error_flags[0]=1 at t+4, first_error=1, test_error=1.
//  3. Short amber. S amber for 2 ticks, then RED (MIN_AMBER=3) -> error_flags[2]=1, first_error=3.
//     Repeat with exactly 3 ticks -> no flag.
//  4. Glitch filter. E shows INVALID for 1 cycle, then back to RED.
//     -> no flag, light_state unchanged. INVALID held for 2 cycles -> flag[5] set.
//  5. Precedence. Walk conflict and arrow conflict in the same cycle -> flags[4:3]=2'b11, first_error=4.
//     Then clear_errors with a persisting violation -> flags 0 that cycle, flags re-set the next cycle.
//  6. Reset mid-run. Flags=6'h21, error_count=9, then not_reset=0 for 1 cycle.
//     -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - seven-segment light decoder, settle filter and safety/sequence checker

module tlm_settle_filter #(
  parameter int W      = 2,
  parameter int SETTLE = 2
) (
  input  logic         clk_27,
  input  logic         not_reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] accepted
);

  // Earlier samples that must all equal the current one (SETTLE must be >= 2).
  localparam int HD = SETTLE - 1;

  logic [W-1:0] hist [HD];
  logic         stable;

  // Raw value is stable once it matches every remembered earlier sample.
  always_comb begin
    stable = 1'b1;
    for (int j = 0; j < HD; j++) begin
      if (hist[j] != raw) stable = 1'b0;
    end
  end

  // Shift the history and accept the raw value after SETTLE equal cycles.
  always_ff @(posedge clk_27) begin
    if (!not_reset) begin
      for (int j = 0; j < HD; j++) hist[j] <= '0;
      accepted <= '0;
    end else begin
      hist[0] <= raw;
      for (int j = 1; j < HD; j++) hist[j] <= hist[j-1];
      if (stable) accepted <= raw;
    end
  end

endmodule

module traffic_light_monitor #(
  parameter int         SETTLE    = 2,
  parameter int         MIN_AMBER = 3,
  parameter logic [6:0] WALK_PAT  = 7'h0C
) (
  input  logic       clk_27,
  input  logic       not_reset,
  input  logic       tick,
  input  logic       clear_errors,
  input  logic [6:0] north_traffic_hex,
  input  logic [6:0] south_hex,
  input  logic [6:0] east_light_hex,
  input  logic [6:0] west_light_hex,
  input  logic [6:0] north_walk_hex,
  input  logic [6:0] south_walk_hex,
  input  logic [6:0] east_walk_hex,
  input  logic [6:0] west_walk_hex,
  output logic [7:0] light_state,
  output logic       left_arrow_on,
  output logic [5:0] error_flags,
  output logic       test_error,
  output logic [2:0] first_error,
  output logic [7:0] error_count
);

  typedef enum logic [1:0] {
    RED     = 2'b00,
    AMBER   = 2'b01,
    GREEN   = 2'b10,
    INVALID = 2'b11
  } light_t;

  // Only seg0 lit: the input registers restart from an all-RED, no-walk picture.
  localparam logic [6:0] RED_PAT     = 7'h7E;
  localparam logic [7:0] MIN_AMBER_C = 8'(MIN_AMBER);

  // Index 0..3 = N, S, E, W throughout.
  logic [3:0][6:0] light_hex_q;
  logic [3:0][6:0] walk_hex_q;
  logic [3:0][1:0] light_raw;
  logic [3:0][1:0] light_raw_q;
  logic [3:0][1:0] light_acc;
  logic [3:0][1:0] light_prev;
  logic [3:0][7:0] amber_cnt;

  logic arrow_raw, arrow_raw_q, arrow_acc;
  logic ns_walk_raw, ns_walk_raw_q, ns_walk_acc;
  logic ew_walk_raw, ew_walk_raw_q, ew_walk_acc;

  logic       ns_busy, ew_busy;
  logic [5:0] viol;
  logic [2:0] first_code;
  logic       unused_segs;

  function automatic light_t decode_light(input logic [6:0] hex);
    case ({~hex[6], ~hex[3], ~hex[0]})
      3'b001:  decode_light = RED;
      3'b100:  decode_light = AMBER;
      3'b010:  decode_light = GREEN;
      default: decode_light = INVALID;
    endcase
  endfunction

  // Register every display bus once.
  always_ff @(posedge clk_27) begin
    if (!not_reset) begin
      light_hex_q <= {4{RED_PAT}};
      walk_hex_q  <= {4{RED_PAT}};
    end else begin
      light_hex_q <= {west_light_hex, east_light_hex, south_hex, north_traffic_hex};
      walk_hex_q  <= {west_walk_hex, east_walk_hex, south_walk_hex, north_walk_hex};
    end
  end

  // Decode registered segments into raw light, arrow and walk values.
  always_comb begin
    for (int i = 0; i < 4; i++) light_raw[i] = decode_light(light_hex_q[i]);
    arrow_raw   = ~light_hex_q[1][2] | ~light_hex_q[1][1];
    ns_walk_raw = (walk_hex_q[0] == WALK_PAT) | (walk_hex_q[1] == WALK_PAT);
    ew_walk_raw = (walk_hex_q[2] == WALK_PAT) | (walk_hex_q[3] == WALK_PAT);
  end

  // Segments that carry no light meaning for the checker.
  assign unused_segs = ^{light_hex_q[0][5:4], light_hex_q[0][2:1],
                         light_hex_q[1][5:4],
                         light_hex_q[2][5:4], light_hex_q[2][2:1],
                         light_hex_q[3][5:4], light_hex_q[3][2:1]};

  // Register the raw decode so it reaches the filters from a flop.
  always_ff @(posedge clk_27) begin
    if (!not_reset) begin
      light_raw_q   <= '0;
      arrow_raw_q   <= 1'b0;
      ns_walk_raw_q <= 1'b0;
      ew_walk_raw_q <= 1'b0;
    end else begin
      light_raw_q   <= light_raw;
      arrow_raw_q   <= arrow_raw;
      ns_walk_raw_q <= ns_walk_raw;
      ew_walk_raw_q <= ew_walk_raw;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_light_filter
    tlm_settle_filter #(.W(2), .SETTLE(SETTLE)) u_filter (
      .clk_27    (clk_27),
      .not_reset (not_reset),
      .raw       (light_raw_q[i]),
      .accepted  (light_acc[i])
    );
  end

  tlm_settle_filter #(.W(1), .SETTLE(SETTLE)) u_arrow_filter (
    .clk_27    (clk_27),
    .not_reset (not_reset),
    .raw       (arrow_raw_q),
    .accepted  (arrow_acc)
  );

  tlm_settle_filter #(.W(1), .SETTLE(SETTLE)) u_ns_walk_filter (
    .clk_27    (clk_27),
    .not_reset (not_reset),
    .raw       (ns_walk_raw_q),
    .accepted  (ns_walk_acc)
  );

  tlm_settle_filter #(.W(1), .SETTLE(SETTLE)) u_ew_walk_filter (
    .clk_27    (clk_27),
    .not_reset (not_reset),
    .raw       (ew_walk_raw_q),
    .accepted  (ew_walk_acc)
  );

  // Remember the previous accepted state and time each amber phase in ticks.
  always_ff @(posedge clk_27) begin
    if (!not_reset) begin
      light_prev <= '0;
      amber_cnt  <= '0;
    end else begin
      light_prev <= light_acc;
      for (int l = 0; l < 4; l++) begin
        if (light_acc[l] == AMBER && light_prev[l] != AMBER) begin
          amber_cnt[l] <= '0;
        end else if (light_acc[l] == AMBER && tick && amber_cnt[l] != 8'hFF) begin
          amber_cnt[l] <= amber_cnt[l] + 8'd1;
        end
      end
    end
  end

  // Evaluate every safety and sequencing rule on accepted values.
  always_comb begin
    viol    = '0;
    ns_busy = (light_acc[0] != RED) || (light_acc[1] != RED);
    ew_busy = (light_acc[2] != RED) || (light_acc[3] != RED);
    viol[0] = ns_busy && ew_busy;
    for (int l = 0; l < 4; l++) begin
      if ((light_prev[l] == GREEN && light_acc[l] == RED)   ||
          (light_prev[l] == RED   && light_acc[l] == AMBER) ||
          (light_prev[l] == AMBER && light_acc[l] == GREEN)) begin
        viol[1] = 1'b1;
      end
      if (light_prev[l] == AMBER && light_acc[l] == RED && amber_cnt[l] < MIN_AMBER_C) begin
        viol[2] = 1'b1;
      end
      if (light_acc[l] == INVALID) viol[5] = 1'b1;
    end
    viol[3] = (ns_walk_acc && (light_acc[2] != RED || light_acc[3] != RED)) ||
              (ew_walk_acc && (light_acc[0] != RED || light_acc[1] != RED));
    viol[4] = arrow_acc && (light_acc[0] != RED || light_acc[2] != RED || light_acc[3] != RED);
  end

  // Lowest violated bit wins when several rules break together.
  always_comb begin
    first_code = '0;
    for (int b = 5; b >= 0; b--) begin
      if (viol[b]) first_code = 3'(b + 1);
    end
  end

  // Sticky flags, first-error capture and saturating violation count.
  always_ff @(posedge clk_27) begin
    if (!not_reset) begin
      error_flags <= '0;
      first_error <= '0;
      error_count <= '0;
    end else if (clear_errors) begin
      error_flags <= '0;
      first_error <= '0;
      error_count <= '0;
    end else if (|viol) begin
      error_flags <= error_flags | viol;
      if (error_flags == 6'h00) first_error <= first_code;
      if (error_count != 8'hFF) error_count <= error_count + 8'd1;
    end
  end

  assign light_state   = {light_acc[0], light_acc[1], light_acc[2], light_acc[3]};
  assign left_arrow_on = arrow_acc;
  assign test_error    = |error_flags;

endmodule
